// File: rtl/cd_sd_arbiter.sv
// rtl/cd_sd_arbiter.sv - shares the HPS sd request channel between TOC lookups and 75 Hz paced sector fetches
module cd_sd_arbiter #(
  parameter int          SECTOR_WORDS  = 1024,
  parameter int          TOC_WORDS     = 2,
  parameter int          SECTOR_PERIOD = 1600000,
  parameter logic [15:0] SEC_REQ_TYPE  = 16'hE100,
  parameter int          TIMEOUT       = 2000000
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        toc_req_i,
  input  logic [15:0] toc_type_i,
  output logic [15:0] toc_word_o,
  output logic        toc_word_valid_o,
  output logic        toc_done_o,
  input  logic        reading_i,
  output logic [15:0] sec_word_o,
  output logic        sec_word_valid_o,
  output logic        msf_inc_o,
  output logic        sec_overrun_o,
  output logic        xfer_timeout_o,
  output logic [15:0] sd_req_type_o,
  output logic        sd_rd_o,
  input  logic        sd_ack_i,
  input  logic [15:0] sd_buff_dout_i,
  input  logic        sd_buff_wr_i
);

  localparam int MAXW = (SECTOR_WORDS > TOC_WORDS) ? SECTOR_WORDS : TOC_WORDS;
  localparam int WC_W = $clog2(MAXW + 2);
  localparam int PC_W = $clog2(SECTOR_PERIOD + 2);
  localparam int TC_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t          state_q, state_d;
  logic            ack_s_q, ack_p_q, wr_s_q, wr_p_q, toc_s_q, toc_p_q;
  logic [15:0]     dout_q;
  logic            toc_pend_q, toc_pend_d, sec_pend_q, sec_pend_d;
  logic            last_sec_q, last_sec_d, cur_sec_q, cur_sec_d;
  logic [15:0]     toc_type_q, toc_type_d;
  logic [PC_W-1:0] pace_q, pace_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [TC_W-1:0] tcnt_q, tcnt_d;
  logic [15:0]     toc_word_q, toc_word_d, sec_word_q, sec_word_d;
  logic            toc_valid_q, toc_valid_d, toc_done_q, toc_done_d;
  logic            sec_valid_q, sec_valid_d, msf_q, msf_d;
  logic            ovr_q, ovr_d, tmo_q, tmo_d, rd_q, rd_d;
  logic [15:0]     req_type_q, req_type_d;

  logic            ack_rise, wr_rise, toc_rise, active;
  logic [WC_W-1:0] target;

  assign ack_rise = ack_s_q & ~ack_p_q;
  assign wr_rise  = wr_s_q & ~wr_p_q;
  assign toc_rise = toc_s_q & ~toc_p_q;
  assign active   = (state_q != S_IDLE);
  assign target   = cur_sec_q ? WC_W'(SECTOR_WORDS) : WC_W'(TOC_WORDS);

  always_comb begin
    state_d     = state_q;
    toc_pend_d  = toc_pend_q;
    sec_pend_d  = sec_pend_q;
    last_sec_d  = last_sec_q;
    cur_sec_d   = cur_sec_q;
    toc_type_d  = toc_type_q;
    pace_d      = pace_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    toc_word_d  = toc_word_q;
    sec_word_d  = sec_word_q;
    req_type_d  = req_type_q;
    rd_d        = rd_q;
    toc_valid_d = 1'b0;
    toc_done_d  = 1'b0;
    sec_valid_d = 1'b0;
    msf_d       = 1'b0;
    ovr_d       = 1'b0;
    tmo_d       = 1'b0;

    if (toc_rise && !toc_pend_q && !(active && !cur_sec_q)) begin
      toc_pend_d = 1'b1;
      toc_type_d = toc_type_i;
    end

    // A tick is dropped if the previous one is still waiting or being served.
    if (!reading_i) begin
      pace_d     = '0;
      sec_pend_d = 1'b0;
    end else if (pace_q == PC_W'(SECTOR_PERIOD - 1)) begin
      pace_d = '0;
      if (sec_pend_q || (active && cur_sec_q)) ovr_d = 1'b1;
      else                                     sec_pend_d = 1'b1;
    end else begin
      pace_d = pace_q + PC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (toc_pend_q && (!sec_pend_q || last_sec_q)) begin
          toc_pend_d = 1'b0;
          req_type_d = toc_type_q;
          rd_d       = 1'b1;
          last_sec_d = 1'b0;
          cur_sec_d  = 1'b0;
          wcnt_d     = '0;
          tcnt_d     = '0;
          state_d    = S_REQ;
        end else if (sec_pend_q) begin
          sec_pend_d = 1'b0;
          req_type_d = SEC_REQ_TYPE;
          rd_d       = 1'b1;
          last_sec_d = 1'b1;
          cur_sec_d  = 1'b1;
          wcnt_d     = '0;
          tcnt_d     = '0;
          state_d    = S_REQ;
        end else begin
          req_type_d = '0;
        end
      end
      S_REQ, S_XFER: begin
        tcnt_d = tcnt_q + TC_W'(1);
        if (state_q == S_REQ && ack_rise) begin
          rd_d    = 1'b0;
          state_d = S_XFER;
        end
        if (wr_rise) begin
          wcnt_d = wcnt_q + WC_W'(1);
          if (cur_sec_q) begin
            sec_word_d  = dout_q;
            sec_valid_d = 1'b1;
          end else begin
            toc_word_d  = dout_q;
            toc_valid_d = 1'b1;
          end
          if (wcnt_q + WC_W'(1) == target) begin
            msf_d      = cur_sec_q;
            toc_done_d = !cur_sec_q;
            req_type_d = '0;
            rd_d       = 1'b0;
            state_d    = S_IDLE;
          end
        end
        // Completion on the final cycle wins over the timeout.
        if (state_d != S_IDLE && tcnt_q == TC_W'(TIMEOUT - 1)) begin
          tmo_d      = 1'b1;
          rd_d       = 1'b0;
          req_type_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ack_s_q     <= 1'b0;
      ack_p_q     <= 1'b0;
      wr_s_q      <= 1'b0;
      wr_p_q      <= 1'b0;
      toc_s_q     <= 1'b0;
      toc_p_q     <= 1'b0;
      dout_q      <= '0;
      toc_pend_q  <= 1'b0;
      sec_pend_q  <= 1'b0;
      last_sec_q  <= 1'b1;
      cur_sec_q   <= 1'b0;
      toc_type_q  <= '0;
      pace_q      <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      toc_word_q  <= '0;
      sec_word_q  <= '0;
      toc_valid_q <= 1'b0;
      toc_done_q  <= 1'b0;
      sec_valid_q <= 1'b0;
      msf_q       <= 1'b0;
      ovr_q       <= 1'b0;
      tmo_q       <= 1'b0;
      rd_q        <= 1'b0;
      req_type_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_s_q     <= sd_ack_i;
      ack_p_q     <= ack_s_q;
      wr_s_q      <= sd_buff_wr_i;
      wr_p_q      <= wr_s_q;
      toc_s_q     <= toc_req_i;
      toc_p_q     <= toc_s_q;
      dout_q      <= sd_buff_dout_i;
      toc_pend_q  <= toc_pend_d;
      sec_pend_q  <= sec_pend_d;
      last_sec_q  <= last_sec_d;
      cur_sec_q   <= cur_sec_d;
      toc_type_q  <= toc_type_d;
      pace_q      <= pace_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      toc_word_q  <= toc_word_d;
      sec_word_q  <= sec_word_d;
      toc_valid_q <= toc_valid_d;
      toc_done_q  <= toc_done_d;
      sec_valid_q <= sec_valid_d;
      msf_q       <= msf_d;
      ovr_q       <= ovr_d;
      tmo_q       <= tmo_d;
      rd_q        <= rd_d;
      req_type_q  <= req_type_d;
    end
  end

  assign toc_word_o       = toc_word_q;
  assign toc_word_valid_o = toc_valid_q;
  assign toc_done_o       = toc_done_q;
  assign sec_word_o       = sec_word_q;
  assign sec_word_valid_o = sec_valid_q;
  assign msf_inc_o        = msf_q;
  assign sec_overrun_o    = ovr_q;
  assign xfer_timeout_o   = tmo_q;
  assign sd_req_type_o    = req_type_q;
  assign sd_rd_o          = rd_q;

endmodule

// File: tb/tb_cd_sd_arbiter.sv
// tb/tb_cd_sd_arbiter.sv - directed self-checking bench for cd_sd_arbiter
module tb_cd_sd_arbiter;
  localparam int SP = 100;
  localparam int SW = 4;
  localparam int TW = 2;
  localparam int TO = 150;

  logic        clk = 1'b0;
  logic        reset, toc_req, reading, sd_ack, sd_buff_wr;
  logic [15:0] toc_type, sd_buff_dout;
  logic [15:0] toc_word, sec_word, sd_req_type;
  logic        toc_word_valid, toc_done, sec_word_valid, msf_inc;
  logic        sec_overrun, xfer_timeout, sd_rd;

  cd_sd_arbiter #(
    .SECTOR_WORDS(SW), .TOC_WORDS(TW), .SECTOR_PERIOD(SP),
    .SEC_REQ_TYPE(16'hE100), .TIMEOUT(TO)
  ) dut (
    .clk_sys_i(clk), .reset_i(reset), .toc_req_i(toc_req), .toc_type_i(toc_type),
    .toc_word_o(toc_word), .toc_word_valid_o(toc_word_valid), .toc_done_o(toc_done),
    .reading_i(reading), .sec_word_o(sec_word), .sec_word_valid_o(sec_word_valid),
    .msf_inc_o(msf_inc), .sec_overrun_o(sec_overrun), .xfer_timeout_o(xfer_timeout),
    .sd_req_type_o(sd_req_type), .sd_rd_o(sd_rd), .sd_ack_i(sd_ack),
    .sd_buff_dout_i(sd_buff_dout), .sd_buff_wr_i(sd_buff_wr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0, c1, highs;
  logic        s_tv, s_sv, s_done, s_inc, s_tv2, s_sv2;
  logic [15:0] s_tw, s_sw, s_type;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int n);
    check("wait_target_ahead", 64'(cyc <= n), 64'(1));
    while (cyc < n) tick();
  endtask

  task automatic do_ack();
    sd_ack = 1'b1;
    tick();
    check("rd_held_before_ack", 64'(sd_rd), 64'(1));
    tick();
    check("rd_drop_after_ack", 64'(sd_rd), 64'(0));
    sd_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_word(input logic [15:0] w);
    sd_buff_dout = w;
    sd_buff_wr   = 1'b1;
    tick();
    tick();
    s_tv = toc_word_valid; s_sv = sec_word_valid; s_tw = toc_word; s_sw = sec_word;
    s_done = toc_done; s_inc = msf_inc; s_type = sd_req_type;
    sd_buff_wr = 1'b0;
    tick();
    s_tv2 = toc_word_valid; s_sv2 = sec_word_valid;
    tick();
  endtask

  task automatic sec_words(input int from, input int to);
    for (int i = from; i < to; i++) begin
      send_word(16'hA000 + 16'(i));
      check("sec_valid", 64'(s_sv), 64'(1));
      check("sec_word", 64'(s_sw), 64'(16'hA000 + 16'(i)));
      check("msf_inc", 64'(s_inc), 64'(i == SW - 1));
      check("sec_valid_one_cycle", 64'(s_sv2), 64'(0));
      check("toc_valid_quiet", 64'(s_tv), 64'(0));
    end
  endtask

  task automatic xfer_sector();
    do_ack();
    sec_words(0, SW);
  endtask

  task automatic xfer_toc(input logic [15:0] w0, input logic [15:0] w1);
    do_ack();
    send_word(w0);
    check("toc_valid0", 64'(s_tv), 64'(1));
    check("toc_word0", 64'(s_tw), 64'(w0));
    check("toc_done_early", 64'(s_done), 64'(0));
    check("toc_valid0_one_cycle", 64'(s_tv2), 64'(0));
    send_word(w1);
    check("toc_valid1", 64'(s_tv), 64'(1));
    check("toc_word1", 64'(s_tw), 64'(w1));
    check("toc_done", 64'(s_done), 64'(1));
    check("req_type_cleared", 64'(s_type), 64'(0));
    check("toc_valid1_one_cycle", 64'(s_tv2), 64'(0));
  endtask

  // Leaves a sector tick and a TOC capture landing on the same edge.
  task automatic both_pending(input logic [15:0] t);
    reading = 1'b0;
    tick();
    tick();
    reading = 1'b1;
    repeat (SP - 2) tick();
    toc_type = t;
    toc_req  = 1'b1;
    tick();
    toc_req  = 1'b0;
    tick();
    check("both_pending_idle", 64'(sd_rd), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {9'd0, toc_word, toc_word_valid, toc_done, sec_word, sec_word_valid,
                msf_inc, sec_overrun, xfer_timeout, sd_req_type, sd_rd}, 64'(0));
  endtask

  initial begin
    reset = 1'b1; toc_req = 1'b0; reading = 1'b0; sd_ack = 1'b0;
    sd_buff_wr = 1'b0; toc_type = 16'h0000; sd_buff_dout = 16'h0000;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    reset = 1'b0;
    tick();

    toc_type = 16'hD100;
    toc_req  = 1'b1;
    tick();
    toc_req  = 1'b0;
    tick();
    check("toc_not_yet", 64'(sd_rd), 64'(0));
    tick();
    check("toc_rd", 64'(sd_rd), 64'(1));
    check("toc_type", 64'(sd_req_type), 64'(16'hD100));
    xfer_toc(16'h0032, 16'h0012);
    check("toc_rd_after", 64'(sd_rd), 64'(0));

    // last grant was TOC: sector wins the tie
    both_pending(16'hD200);
    tick();
    check("rr1_first_rd", 64'(sd_rd), 64'(1));
    check("rr1_first_sec", 64'(sd_req_type), 64'(16'hE100));
    xfer_sector();
    check("rr1_second_rd", 64'(sd_rd), 64'(1));
    check("rr1_second_toc", 64'(sd_req_type), 64'(16'hD200));
    xfer_toc(16'h1111, 16'h2222);

    reading = 1'b0;
    tick();
    tick();
    reading = 1'b1;
    c0 = cyc;
    wait_until(c0 + SP);
    check("pace_no_rd_yet", 64'(sd_rd), 64'(0));
    tick();
    check("pace_rd1", 64'(sd_rd), 64'(1));
    check("pace_type1", 64'(sd_req_type), 64'(16'hE100));
    xfer_sector();
    wait_until(c0 + 2 * SP);
    check("pace_no_rd2_yet", 64'(sd_rd), 64'(0));
    tick();
    check("pace_rd2", 64'(sd_rd), 64'(1));
    wait_until(c0 + 3 * SP - 1);
    check("overrun_before", 64'(sec_overrun), 64'(0));
    tick();
    check("overrun_pulse", 64'(sec_overrun), 64'(1));
    tick();
    check("overrun_one_cycle", 64'(sec_overrun), 64'(0));
    wait_until(c0 + 2 * SP + 1 + TO - 1);
    check("tmo_before", 64'(xfer_timeout), 64'(0));
    check("tmo_rd_still", 64'(sd_rd), 64'(1));
    tick();
    check("tmo_pulse", 64'(xfer_timeout), 64'(1));
    check("tmo_rd_low", 64'(sd_rd), 64'(0));
    check("tmo_type_zero", 64'(sd_req_type), 64'(0));
    tick();
    check("tmo_one_cycle", 64'(xfer_timeout), 64'(0));
    wait_until(c0 + 4 * SP);
    check("tmo_not_requeued", 64'(sd_rd), 64'(0));
    tick();
    check("pace_rd3", 64'(sd_rd), 64'(1));
    check("pace_type3", 64'(sd_req_type), 64'(16'hE100));

    do_ack();
    sec_words(0, 2);
    reset   = 1'b1;
    reading = 1'b0;
    tick();
    check_all_zero("reset_mid_xfer");
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      send_word(16'h7777);
      check("stray_sec_valid", 64'(s_sv), 64'(0));
      check("stray_toc_valid", 64'(s_tv), 64'(0));
      check("stray_msf", 64'(s_inc), 64'(0));
      check("stray_sec_valid2", 64'(s_sv2), 64'(0));
    end

    // after reset the last grant is SECTOR: TOC wins the tie
    both_pending(16'hD400);
    tick();
    check("rr2_first_rd", 64'(sd_rd), 64'(1));
    check("rr2_first_toc", 64'(sd_req_type), 64'(16'hD400));
    xfer_toc(16'h5555, 16'h6666);
    check("rr2_second_rd", 64'(sd_rd), 64'(1));
    check("rr2_second_sec", 64'(sd_req_type), 64'(16'hE100));
    xfer_sector();

    reading = 1'b0;
    tick();
    tick();
    reading = 1'b1;
    c1 = cyc;
    wait_until(c1 + SP + 1);
    check("stop_rd", 64'(sd_rd), 64'(1));
    do_ack();
    sec_words(0, 2);
    reading = 1'b0;
    sec_words(2, SW);
    highs = 0;
    repeat (250) begin
      tick();
      if (sd_rd) highs++;
    end
    check("stop_no_requests", 64'(highs), 64'(0));
    check("stop_pace_zero", 64'(dut.pace_q), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cd_sd_arbiter.md
Name: cd_sd_arbiter

Overview:
- Shares the single HPS sd request channel (sd_rd / sd_req_type / sd_ack / sd_buff_wr) between two requesters: TOC lookups from the CDD emulation, and paced sector fetches during playback.
- Generates the 75 Hz sector cadence while reading.
- Issues one msf_inc pulse per completed sector, so the drive's MSF advances in lockstep with delivered data.
- Sits between the CD drive block, the sector buffer, and the HPS interface.

Parameters:
SECTOR_WORDS, 1024, 16-bit words per sector transfer (2048 bytes)
TOC_WORDS, 2, 16-bit words per TOC transfer
SECTOR_PERIOD, 1600000, clk_sys cycles between sector ticks (120 MHz / 75)
SEC_REQ_TYPE, 16'hE100, sd_req_type code for a sector fetch
TIMEOUT, 2000000, max cycles a transfer may stay in REQ+XFER

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high reset
toc_req  in  1  TOC request; rising edge captured
toc_type  in  16  TOC request code (Dxxx), latched at capture
toc_word  out  16  received TOC word
toc_word_valid  out  1  one-cycle strobe per TOC word
toc_done  out  1  one-cycle pulse, TOC transfer complete
reading  in  1  playback active
sec_word  out  16  received sector word
sec_word_valid  out  1  one-cycle strobe per sector word
msf_inc  out  1  one-cycle pulse, sector complete
sec_overrun  out  1  one-cycle pulse, sector tick dropped
xfer_timeout  out  1  one-cycle pulse, transfer aborted
sd_req_type  out  16  request code to HPS
sd_rd  out  1  request strobe to HPS
sd_ack  in  1  HPS acknowledge
sd_buff_dout  in  16  HPS data word
sd_buff_wr  in  1  HPS word strobe

Behaviour:
- Reset: all outputs 0, sd_req_type 16'h0000, state IDLE, pending flags clear, pacing counter 0, last_grant = SECTOR. Reset mid-transfer aborts immediately with no done/msf_inc pulse.
- Edge detect: sd_ack, sd_buff_wr and toc_req are registered; an edge means cur=1 and prev=0.
- TOC capture: a toc_req rising edge sets toc_pend and latches toc_type. Ignored while toc_pend is set or a TOC transfer is active.
- Pacing:
  - While reading=1, the counter runs 0..SECTOR_PERIOD-1. At terminal count it wraps to 0 and sets sec_pend.
  - If sec_pend is already set at the tick, or a sector transfer is active, sec_overrun pulses and the tick is dropped.
  - reading=0 clears the counter and sec_pend; an in-flight sector transfer still completes.
- FSM IDLE:
  - Grant goes to the pending requester. If both are pending, grant the one not equal to last_grant (round-robin).
  - On grant: drive sd_req_type (latched toc_type or SEC_REQ_TYPE), set sd_rd=1, clear that pending flag, update last_grant, clear word and timeout counters, go to REQ.
  - Nothing pending: sd_req_type=0.
- FSM REQ: on sd_ack rising edge, sd_rd goes 0 the next cycle; go to XFER.
- Words (REQ and XFER):
  - Each sd_buff_wr rising edge registers sd_buff_dout onto toc_word or sec_word, with the matching valid asserted for exactly the next cycle. Word count increments.
  - Edges arriving in IDLE are ignored.
- Completion:
  - When the count reaches TOC_WORDS or SECTOR_WORDS, pulse toc_done or msf_inc in the same cycle as the last valid strobe.
  - sd_req_type returns to 0 and the FSM returns to IDLE. A new grant is possible the cycle after.
- Timeout: when the cycle count in REQ+XFER reaches TIMEOUT, xfer_timeout pulses, sd_rd=0, sd_req_type=0, go to IDLE. No done or msf_inc pulse; the aborted request is not re-queued.
- Latency: grant to sd_rd high is 1 cycle from IDLE with a pending flag.
- Simultaneous events: a sector tick coinciding with a TOC capture sets both flags. Completion and a new pending flag in the same cycle are both honored.
- Counters are sized to hold their parameters plus 1; no wrap inside a transfer.

Test Plan:
- Reset, then a toc_req pulse with toc_type=16'hD100 -> sd_rd=1 and sd_req_type=D100 the next cycle. Ack, then words 0x0032 and 0x0012 -> two toc_word_valid strobes carrying those values, toc_done with the second, sd_req_type=0 after.
- reading=1 with SECTOR_PERIOD=100 and SECTOR_WORDS=4 -> sd_rd at cycle 100 with E100. Four words -> four sec_word_valid and one msf_inc. Next request at cycle 200.
- toc_req and a sector tick pending together with last_grant=SECTOR -> TOC granted first, sector second. Repeat with last_grant=TOC -> order reversed.
- HPS never acks a sector request, reading held -> the next tick pulses sec_overrun. At TIMEOUT, xfer_timeout pulses, sd_rd=0, FSM back in IDLE.
- reset asserted after 2 of 4 sector words -> all outputs 0 the next cycle, no msf_inc. Stray sd_buff_wr edges in IDLE produce no valid strobes.
- reading deasserted mid-sector -> the transfer finishes with msf_inc, no further requests are issued, and the counter stays at 0.
